branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor.sv | 133 +++++++++++++
 tb/tb_branch_target_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_predictor
// Purpose  : Direct-mapped BTB with per-entry saturating direction counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic                jump_d   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic [31:0]         stat_updates_q, stat_updates_d;
  logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                up_hit;
  logic                unused_pc_bits;

  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign lk_tag = lookup_pc[31:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[31:IDX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so same-cycle updates are not visible.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && (jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    jump_d   = jump_q;
    ctr_d    = ctr_q;
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid) begin
      if (upd_is_branch || upd_is_jump) stat_updates_d = stat_updates_q + 32'd1;
      if (upd_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      if (upd_is_jump) begin
        // Jump wins over the branch flag; a taken miss allocates, any hit refreshes.
        if (up_hit || upd_taken) begin
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = upd_target;
          jump_d[up_idx]   = 1'b1;
          ctr_d[up_idx]    = CTR_MAX;
        end
      end else if (upd_is_branch) begin
        if (up_hit) begin
          jump_d[up_idx] = 1'b0;
          if (upd_taken) begin
            target_d[up_idx] = upd_target;
            if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
          end else if (ctr_q[up_idx] != '0) begin
            ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
          end
        end else if (upd_taken) begin
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = upd_target;
          jump_d[up_idx]   = 1'b0;
          ctr_d[up_idx]    = CTR_INIT;
        end
      end else if (up_hit) begin
        valid_d[up_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= '0;
      end
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      jump_q   <= jump_d;
      ctr_q    <= ctr_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_predictor
// Purpose  : Directed self-checking bench for branch_target_predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] lookup_pc = 32'h100;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_branch = 1'b0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] stat_updates, stat_mispredicts;

  int total = 0;
  int bad   = 0;
  int n_upd = 0;

  branch_target_predictor #(.ENTRIES(64), .CTR_BITS(2)) dut (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input string name,
                      input logic hit, input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({name, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
    chk({name, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({name, ".target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                     input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
    if (br || jmp) n_upd++;
    @(posedge clock); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge clock);
    #1;
    look(32'h100, "rst", 1'b0, 1'b0, 32'h104);
    chk("rst.stat_upd", stat_updates, 32'd0);
    chk("rst.stat_mis", stat_mispredicts, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Allocation on empty table; same-cycle lookup still sees old contents.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h80; n_upd++;
    lookup_pc = 32'h100; #1;
    chk("same_cycle.hit", {31'd0, pred_hit}, 32'd0);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    look(32'h100, "alloc", 1'b1, 1'b1, 32'h80);
    chk("alloc.stat_upd", stat_updates, 32'd1);

    // Counter 2 -> 1 -> 0 -> 0; non-taken updates must not touch target.
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'hDEAD0, 1'b0);
    look(32'h100, "nt1", 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'hDEAD0, 1'b0);
    look(32'h100, "nt2", 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'hDEAD0, 1'b0);
    look(32'h100, "nt3_floor", 1'b1, 1'b0, 32'h104);
    // 0 -> 1 (still not taken, proves no underflow wrap) -> 2 with new target.
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
    look(32'h100, "t1", 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
    look(32'h100, "t2", 1'b1, 1'b1, 32'h90);
    // Three taken from 2 saturate at 3; then 3 -> 2 taken, 2 -> 1 not taken.
    repeat (3) upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'hBAD0, 1'b0);
    look(32'h100, "sat_nt1", 1'b1, 1'b1, 32'h90);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'hBAD0, 1'b0);
    look(32'h100, "sat_nt2", 1'b1, 1'b0, 32'h104);

    // Aliasing jump (both type flags) evicts entry at index 0.
    upd(32'h200, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0);
    look(32'h100, "alias_old", 1'b0, 1'b0, 32'h104);
    look(32'h200, "jump", 1'b1, 1'b1, 32'h400);
    // Jump allocates counter at max: one not-taken branch update keeps it taken.
    upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h200, "jump_ctr", 1'b1, 1'b1, 32'h400);
    upd(32'h200, 1'b0, 1'b1, 1'b0, 32'h440, 1'b0);
    look(32'h200, "jump_hit", 1'b1, 1'b1, 32'h440);
    // Non-control miss changes nothing, hit invalidates.
    upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h200, "nc_miss", 1'b1, 1'b1, 32'h440);
    upd(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h200, "nc_hit", 1'b0, 1'b0, 32'h204);
    // Branch not-taken miss does not allocate.
    upd(32'h104, 1'b1, 1'b0, 1'b0, 32'h700, 1'b0);
    look(32'h104, "nt_miss", 1'b0, 1'b0, 32'h108);

    // upd_valid low ignores everything.
    upd_pc = 32'h108; upd_is_branch = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h900; upd_mispredict = 1'b1;
    @(posedge clock); #1;
    upd_mispredict = 1'b0;
    look(32'h108, "novalid", 1'b0, 1'b0, 32'h10C);
    chk("novalid.stat_upd", stat_updates, n_upd);
    chk("novalid.stat_mis", stat_mispredicts, 32'd0);

    repeat (5) upd(32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("mispred5", stat_mispredicts, 32'd5);
    chk("stat_upd_total", stat_updates, n_upd);
    look(32'hFFFF_FFFC, "pc_wrap", 1'b0, 1'b0, 32'h0);

    // Learned entry, then reset with a simultaneous update.
    upd(32'h140, 1'b1, 1'b0, 1'b1, 32'hA00, 1'b0);
    look(32'h140, "pre_rst", 1'b1, 1'b1, 32'hA00);
    reset = 1'b1;
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    reset = 1'b0;
    look(32'h140, "rst_learned", 1'b0, 1'b0, 32'h144);
    look(32'h100, "rst_upd", 1'b0, 1'b0, 32'h104);
    chk("rst2.stat_upd", stat_updates, 32'd0);
    chk("rst2.stat_mis", stat_mispredicts, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
